ahb_sram_slave: RTL and testbench

- AHB-Lite slave SRAM model sitting directly downstream of the AHB arbiter in the testbench fabric.
- Consumes the arbiter's output bus (`auto_out_*` on the arbiter, `auto_in_*` here) and returns `hreadyout`/`hresp`/`hrdata` to it.
- Provides word-addressed backing storage with programmable wait states and two-cycle ERROR responses, giving the core a realistic pipelined slave.

---
 rtl/ahb_sram_slave_if.sv | 26 ++
 rtl/ahb_sram_slave.sv | 147 ++++++++++++++
 tb/tb_ahb_sram_slave.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between the arbiter output and the SRAM slave.
// The master modport is the arbiter side; the slave modport is the SRAM side.
interface ahb_sram_slave_if;
    logic        hready;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hwrite;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [29:0] haddr;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hready, htrans, hsize, hburst, hwrite, hprot, hmastlock, haddr, hwdata,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hready, htrans, hsize, hburst, hwrite, hprot, hmastlock, haddr, hwdata,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-addressed storage, WAIT_STATES wait cycles per
// beat, back-to-back pipelining. Illegal transfers (bad size, misaligned,
// out of range) get a two-cycle ERROR response when AHB_SRAM_ERROR_EN is
// defined; otherwise they complete as OKAY with no write and zero read data.
module ahb_sram_slave #(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic            clock,
    input  logic            reset,
    ahb_sram_slave_if.slave auto_in
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_XFER
`ifdef AHB_SRAM_ERROR_EN
        , S_ERR1,
        S_ERR2
`endif
    } state_t;

    state_t               state, state_nxt;
    logic [2:0]           cnt, cnt_nxt;
    logic [ADDR_BITS+1:0] addr_q;
    logic [1:0]           size_q;
    logic                 write_q;
    logic                 legal_q;

    logic                 ready;
    logic                 resp;
    logic                 accept;
    logic                 aligned;
    logic                 in_range;
    logic                 legal_in;
    logic [3:0]           be;
    logic [31:0]          mem [DEPTH];

    // ignored bus attributes; kept only so they count as consumed
    logic unused_ok;
    assign unused_ok = ^{auto_in.hburst, auto_in.hprot, auto_in.hmastlock};

    // output flags decoded purely from registered state
    always_comb begin
        ready = 1'b1;
        resp  = 1'b0;
        if (state == S_WAIT) ready = 1'b0;
`ifdef AHB_SRAM_ERROR_EN
        if (state == S_ERR1) ready = 1'b0;
        if (state == S_ERR1 || state == S_ERR2) resp = 1'b1;
`endif
    end

    assign auto_in.hreadyout = ready;
    assign auto_in.hresp     = resp;

    // address-phase legality check; own readiness also gates acceptance so a
    // stray hready during our own stall cannot clobber the live data phase
    always_comb begin
        case (auto_in.hsize)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = ~auto_in.haddr[0];
            3'd2:    aligned = (auto_in.haddr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        in_range = ((auto_in.haddr >> (ADDR_BITS + 2)) == '0);
        legal_in = (auto_in.hsize <= 3'd2) && aligned && in_range;
        accept   = auto_in.hready && auto_in.htrans[1] && ready;
    end

    // next state and wait counter; a new acceptance overrides XFER/ERR2 -> IDLE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_WAIT: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) state_nxt = S_XFER;
            end
`ifdef AHB_SRAM_ERROR_EN
            S_ERR1:  state_nxt = S_ERR2;
`endif
            default: state_nxt = S_IDLE;
        endcase
        if (accept) begin
            cnt_nxt = 3'd0;
`ifdef AHB_SRAM_ERROR_EN
            if (!legal_in) begin
                state_nxt = S_ERR1;
            end else
`endif
            if (WAIT_STATES > 0) begin
                state_nxt = S_WAIT;
                cnt_nxt   = 3'(WAIT_STATES);
            end else begin
                state_nxt = S_XFER;
            end
        end
    end

    // state register and data-phase capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            addr_q  <= '0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
            legal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q  <= auto_in.haddr[ADDR_BITS+1:0];
                size_q  <= auto_in.hsize[1:0];
                write_q <= auto_in.hwrite;
                legal_q <= legal_in;
            end
        end
    end

    // byte-lane enables for the completing write
    always_comb begin
        case (size_q)
            2'd0:    be = 4'b0001 << addr_q[1:0];
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // storage write at the edge ending XFER; memory itself is never reset
    always_ff @(posedge clock) begin
        if (!reset && state == S_XFER && write_q && legal_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr_q[ADDR_BITS+1:2]][8*i +: 8] <= auto_in.hwdata[8*i +: 8];
            end
        end
    end

    // read data only during a legal read XFER; async read sees same-edge writes
    always_comb begin
        auto_in.hrdata = '0;
        if (state == S_XFER && !write_q && legal_q) auto_in.hrdata = mem[addr_q[ADDR_BITS+1:2]];
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (WAIT_STATES 0/2/3) behind one
// driver selected by sel; table vectors, hand sequences and randomized
// traffic against a byte-lane memory model.
module tb_ahb_sram_slave;
`ifdef AHB_SRAM_ERROR_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  sel;
    logic [1:0]  tb_htrans;
    logic [2:0]  tb_hsize;
    logic        tb_hwrite;
    logic [29:0] tb_haddr;
    logic [31:0] tb_hwdata;
    logic        ho, hr;
    logic [31:0] hd;
    logic [2:0]  ho_v, hr_v;
    logic [31:0] hd_v [3];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ahb_sram_slave_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        assign bus[g].hready    = bus[g].hreadyout;
        assign bus[g].htrans    = (sel == 2'(g)) ? tb_htrans : 2'b00;
        assign bus[g].hsize     = tb_hsize;
        assign bus[g].hburst    = 3'd0;
        assign bus[g].hwrite    = tb_hwrite;
        assign bus[g].hprot     = 4'b0011;
        assign bus[g].hmastlock = 1'b0;
        assign bus[g].haddr     = tb_haddr;
        assign bus[g].hwdata    = tb_hwdata;
        assign ho_v[g]          = bus[g].hreadyout;
        assign hr_v[g]          = bus[g].hresp;
        assign hd_v[g]          = bus[g].hrdata;
        ahb_sram_slave #(.ADDR_BITS(12), .WAIT_STATES(W)) u_dut (
            .clock   (clock),
            .reset   (reset),
            .auto_in (bus[g])
        );
    end

    always_comb begin
        case (sel)
            2'd1:    begin ho = ho_v[1]; hr = hr_v[1]; hd = hd_v[1]; end
            2'd2:    begin ho = ho_v[2]; hr = hr_v[2]; hd = hd_v[2]; end
            default: begin ho = ho_v[0]; hr = hr_v[0]; hd = hd_v[0]; end
        endcase
    end

    function automatic int ws(input logic [1:0] s);
        return (s == 2'd0) ? 0 : (s == 2'd1) ? 2 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // one isolated transfer: address phase, then sample each data-phase cycle
    task automatic xfer(input logic [1:0] s, input logic w, input logic [29:0] a,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output logic rsp, output int waits,
                        output logic rsp1);
        bit done;
        @(negedge clock);
        sel = s; tb_htrans = 2'b10; tb_hwrite = w; tb_haddr = a; tb_hsize = sz; tb_hwdata = wd;
        @(posedge clock);
        waits = 0; rd = '0; rsp = 1'b0; rsp1 = 1'b0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clock);
            tb_htrans = 2'b00;
            if (c == 0) rsp1 = hr;
            if (ho) begin rd = hd; rsp = hr; done = 1'b1; end
            else waits++;
            @(posedge clock);
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [1:0]  s;
        logic        w;
        logic [29:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ersp;
        int          ew;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] mdl [3][32];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] rd, wd, er;
        logic        rsp, rsp1, w, oob, ersp;
        int          waits, k, off, ew;
        logic [1:0]  s;
        logic [2:0]  sz;
        logic [29:0] a;

        reset = 1'b1; sel = 2'd0; tb_htrans = 2'b00; tb_hsize = 3'd0;
        tb_hwrite = 1'b0; tb_haddr = '0; tb_hwdata = '0;
        repeat (2) @(negedge clock);
        chk("rst_hreadyout", 32'(ho), 32'd1);
        chk("rst_hresp", 32'(hr), 32'd0);
        chk("rst_hrdata", hd, 32'd0);
        reset = 1'b0;

        tbl[0]  = '{2'd0, 1'b1, 30'h40,   3'd2, 32'hA5A50F0F, 32'h0,        1'b0, 0};
        tbl[1]  = '{2'd0, 1'b0, 30'h40,   3'd2, 32'h0,        32'hA5A50F0F, 1'b0, 0};
        tbl[2]  = '{2'd0, 1'b1, 30'h41,   3'd0, 32'h00007700, 32'h0,        1'b0, 0};
        tbl[3]  = '{2'd0, 1'b0, 30'h42,   3'd1, 32'h0,        32'hA5A5770F, 1'b0, 0};
        tbl[4]  = '{2'd1, 1'b1, 30'h44,   3'd2, 32'h01020304, 32'h0,        1'b0, 2};
        tbl[5]  = '{2'd1, 1'b1, 30'h46,   3'd1, 32'hBEEF0000, 32'h0,        1'b0, 2};
        tbl[6]  = '{2'd1, 1'b0, 30'h44,   3'd2, 32'h0,        32'hBEEF0304, 1'b0, 2};
        tbl[7]  = '{2'd2, 1'b1, 30'h48,   3'd2, 32'h0BADF00D, 32'h0,        1'b0, 3};
        tbl[8]  = '{2'd2, 1'b0, 30'h48,   3'd0, 32'h0,        32'h0BADF00D, 1'b0, 3};
        tbl[9]  = '{2'd0, 1'b0, 30'h43,   3'd1, 32'h0,        32'h0,        EE,   EE ? 1 : 0};
        tbl[10] = '{2'd1, 1'b1, 30'h40,   3'd3, 32'hFFFFFFFF, 32'h0,        EE,   EE ? 1 : 2};
        tbl[11] = '{2'd2, 1'b0, 30'h5000, 3'd2, 32'h0,        32'h0,        EE,   EE ? 1 : 3};
        foreach (tbl[i]) begin
            xfer(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].wd, rd, rsp, waits, rsp1);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].er);
            chk($sformatf("vec%0d_hresp", i), 32'(rsp), 32'(tbl[i].ersp));
            chk($sformatf("vec%0d_waits", i), 32'(waits), 32'(tbl[i].ew));
        end

        // zero-wait back-to-back write then read of the same word
        @(negedge clock);
        sel = 2'd0; tb_htrans = 2'b10; tb_hwrite = 1'b1; tb_haddr = 30'h10; tb_hsize = 3'd2;
        @(posedge clock);
        @(negedge clock);
        chk("b2b_wr_ready", 32'(ho), 32'd1);
        tb_htrans = 2'b10; tb_hwrite = 1'b0; tb_haddr = 30'h10; tb_hwdata = 32'hDEADBEEF;
        @(posedge clock);
        @(negedge clock);
        chk("b2b_rd_ready", 32'(ho), 32'd1);
        chk("b2b_rd_data", hd, 32'hDEADBEEF);
        tb_htrans = 2'b00;
        @(posedge clock);
        @(negedge clock);
        chk("b2b_idle_data", hd, 32'd0);
        chk("b2b_idle_ready", 32'(ho), 32'd1);
        @(posedge clock);

        // byte write with two wait states
        xfer(2'd1, 1'b1, 30'h10, 3'd2, 32'h11223344, rd, rsp, waits, rsp1);
        xfer(2'd1, 1'b1, 30'h13, 3'd0, 32'hAB000000, rd, rsp, waits, rsp1);
        chk("byte_wr_waits", 32'(waits), 32'd2);
        xfer(2'd1, 1'b0, 30'h10, 3'd2, 32'h0, rd, rsp, waits, rsp1);
        chk("byte_rd_data", rd, 32'hAB223344);

        // BUSY with hready high: no acceptance, no write
        @(negedge clock);
        sel = 2'd0; tb_htrans = 2'b01; tb_hwrite = 1'b1; tb_haddr = 30'h10; tb_hsize = 3'd2;
        tb_hwdata = 32'h0;
        @(posedge clock);
        @(negedge clock);
        chk("busy_ready", 32'(ho), 32'd1);
        chk("busy_hresp", 32'(hr), 32'd0);
        tb_htrans = 2'b00;
        @(posedge clock);
        xfer(2'd0, 1'b0, 30'h10, 3'd2, 32'h0, rd, rsp, waits, rsp1);
        chk("busy_mem", rd, 32'hDEADBEEF);

`ifdef AHB_SRAM_ERROR_EN
        // out-of-range read on the 3-wait instance: still exactly two cycles
        xfer(2'd2, 1'b0, 30'h4000, 3'd2, 32'h0, rd, rsp, waits, rsp1);
        chk("oor_cyc1_hresp", 32'(rsp1), 32'd1);
        chk("oor_cyc1_lowready", 32'(waits), 32'd1);
        chk("oor_cyc2_hresp", 32'(rsp), 32'd1);
        @(negedge clock);
        chk("oor_idle_ready", 32'(ho), 32'd1);
        chk("oor_idle_hresp", 32'(hr), 32'd0);
        @(posedge clock);
`else
        // misaligned halfword: OKAY, no write, zero read data
        xfer(2'd0, 1'b1, 30'h00, 3'd2, 32'h55667788, rd, rsp, waits, rsp1);
        xfer(2'd0, 1'b1, 30'h01, 3'd1, 32'hFFFFFFFF, rd, rsp, waits, rsp1);
        chk("mis_wr_hresp", 32'(rsp), 32'd0);
        xfer(2'd0, 1'b0, 30'h01, 3'd1, 32'h0, rd, rsp, waits, rsp1);
        chk("mis_rd_hresp", 32'(rsp), 32'd0);
        chk("mis_rd_data", rd, 32'd0);
        xfer(2'd0, 1'b0, 30'h00, 3'd2, 32'h0, rd, rsp, waits, rsp1);
        chk("mis_mem", rd, 32'h55667788);
`endif

        // randomized traffic over words 0x100..0x11F of each instance
        for (int si = 0; si < 3; si++) begin
            for (int j = 0; j < 32; j++) begin
                wd = $urandom;
                mdl[si][j] = wd;
                xfer(2'(si), 1'b1, 30'h400 + 30'(j * 4), 3'd2, wd, rd, rsp, waits, rsp1);
            end
        end
        for (int n = 0; n < 150; n++) begin
            s   = 2'($urandom_range(0, 2));
            w   = 1'($urandom_range(0, 1));
            sz  = 3'($urandom_range(0, 2));
            k   = $urandom_range(0, 31);
            off = (sz == 3'd0) ? $urandom_range(0, 3) : (sz == 3'd1) ? 2 * $urandom_range(0, 1) : 0;
            oob = ($urandom_range(0, 9) == 0);
            a   = 30'h400 + 30'(k * 4 + off) + (oob ? 30'h4000 : 30'h0);
            wd  = $urandom;
            ersp = oob && EE;
            ew   = ersp ? 1 : ws(s);
            er   = (!w && !oob) ? mdl[s][k] : 32'd0;
            xfer(s, w, a, sz, wd, rd, rsp, waits, rsp1);
            chk($sformatf("rnd%0d_rdata", n), rd, er);
            chk($sformatf("rnd%0d_hresp", n), 32'(rsp), 32'(ersp));
            chk($sformatf("rnd%0d_waits", n), 32'(waits), 32'(ew));
            if (w && !oob) begin
                for (int b = 0; b < 4; b++) begin
                    if (sz == 3'd2 || (sz == 3'd1 && b / 2 == off / 2) || (sz == 3'd0 && b == off))
                        mdl[s][k][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end

        // reset in the middle of a 3-wait write: outputs snap back, write is lost
        xfer(2'd2, 1'b1, 30'h20, 3'd2, 32'hCAFEF00D, rd, rsp, waits, rsp1);
        @(negedge clock);
        sel = 2'd2; tb_htrans = 2'b10; tb_hwrite = 1'b1; tb_haddr = 30'h20; tb_hsize = 3'd2;
        tb_hwdata = 32'h12345678;
        @(posedge clock);
        @(negedge clock);
        tb_htrans = 2'b00;
        chk("rst_mid_wait", 32'(ho), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(ho), 32'd1);
        chk("rst_mid_hresp", 32'(hr), 32'd0);
        chk("rst_mid_hrdata", hd, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        xfer(2'd2, 1'b0, 30'h20, 3'd2, 32'h0, rd, rsp, waits, rsp1);
        chk("rst_keep_data", rd, 32'hCAFEF00D);
        chk("rst_keep_waits", 32'(waits), 32'd3);
        xfer(2'd0, 1'b0, 30'h10, 3'd2, 32'h0, rd, rsp, waits, rsp1);
        chk("rst_keep_other", rd, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
